// File: rtl/adc_emu_pkg.sv
// adc_emu_pkg: shared types and constants for the AD7352-style SPI ADC emulator.
// Provides the sample-source mode enum, noise LFSR constants and the frame width helper.
package adc_emu_pkg;

   typedef enum logic [1:0] {
      MODE_PLAYBACK = 2'd0,
      MODE_RAMP     = 2'd1,
      MODE_PATTERN  = 2'd2,
      MODE_RSVD     = 2'd3
   } adc_mode_e;

   // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form (bits 15,13,12,10)
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic int frame_width(input int lead_z,
                                      input int data_w,
                                      input int trail_z);
      return lead_z + data_w + trail_z;
   endfunction

endpackage

// File: rtl/adc_emu_chan_shifter.sv
// adc_emu_chan_shifter: one ADC channel -- sample bank, prefetch, source mux, frame shifter.
// Ports: clk/rst_n; wr_en/wr_addr/wr_data bank write; index playback address;
//   load (frame start), shift (serial clock fall), mode, zero (buffer exhausted);
//   noise (only with ADC_EMU_NOISE_EN); sdo serial bit.
module adc_emu_chan_shifter
   import adc_emu_pkg::*;
#(
   parameter int CH_ID   = 0,
   parameter int DATA_W  = 12,
   parameter int LEAD_Z  = 2,
   parameter int TRAIL_Z = 2,
   parameter int DEPTH   = 32768,
   localparam int IW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [IW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [IW-1:0]     index,
   input  logic              load,
   input  logic              shift,
   input  logic [1:0]        mode,
   input  logic              zero,
`ifdef ADC_EMU_NOISE_EN
   input  logic [1:0]        noise,
`endif
   output logic              sdo
);

   localparam int FW = frame_width(LEAD_Z, DATA_W, TRAIL_Z);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] pf;
   logic [DATA_W-1:0] pat;
   logic [DATA_W-1:0] ridx;
   logic [DATA_W-1:0] ramp;
   logic [DATA_W-1:0] play;
   logic [DATA_W-1:0] sample;
   logic [FW-1:0]     sr;
   adc_mode_e         m;

   assign m = adc_mode_e'(mode);

   // Read-first bank: a write to the prefetched address shows up a cycle later.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      pf <= mem[index];
   end

   // MSB-first alternating pattern; odd channels are the complement.
   always_comb begin
      pat = '0;
      for (int i = 0; i < DATA_W; i++)
         pat[i] = ((((DATA_W - 1 - i) % 2) == 0) ^ ((CH_ID % 2) == 1));
   end

   if (IW >= DATA_W) begin : g_rtrunc
      assign ridx = index[DATA_W-1:0];
   end else begin : g_rext
      assign ridx = {{(DATA_W-IW){1'b0}}, index};
   end

   assign ramp = ridx + DATA_W'(CH_ID);

`ifdef ADC_EMU_NOISE_EN
   // Two extra headroom bits: top bit flags underflow, next flags overflow.
   logic [DATA_W+1:0] nsum;
   assign nsum = {2'b00, pf} + {{DATA_W{noise[1]}}, noise};
   always_comb begin
      play = nsum[DATA_W-1:0];
      if (nsum[DATA_W+1])   play = '0;
      else if (nsum[DATA_W]) play = '1;
   end
`else
   assign play = pf;
`endif

   always_comb begin
      sample = play;
      case (m)
         MODE_RAMP:    sample = ramp;
         MODE_PATTERN: sample = pat;
         default:      sample = play;
      endcase
      if (zero) sample = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sr  <= '0;
         sdo <= 1'b0;
      end else if (load) begin
         sr  <= FW'(sample) << TRAIL_Z;
         sdo <= 1'b0;
      end else if (shift) begin
         sdo <= sr[FW-1];
         sr  <= sr << 1;
      end
   end

endmodule

// File: rtl/adc_spi_emulator.sv
// adc_spi_emulator: AD7352-style SPI ADC slave serving framed samples from loadable banks.
// Ports: clk_50M, rst_n (sync, active-low); ad_cs/ad_clk from master; cycle_start (T0);
//   mode; wr_en/wr_ch/wr_addr/wr_data bank writes; ad_in serial data per channel;
//   busy, exhausted, frame_cnt status. Build option: ADC_EMU_NOISE_EN adds LFSR dither.
module adc_spi_emulator
   import adc_emu_pkg::*;
#(
   parameter int CHANNELS = 2,
   parameter int DATA_W   = 12,
   parameter int LEAD_Z   = 2,
   parameter int TRAIL_Z  = 2,
   parameter int DEPTH    = 32768,
   parameter int WRAP     = 0,
   localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int IW      = $clog2(DEPTH)
) (
   input  logic                clk_50M,
   input  logic                rst_n,
   input  logic                ad_cs,
   input  logic                ad_clk,
   input  logic                cycle_start,
   input  logic [1:0]          mode,
   input  logic                wr_en,
   input  logic [CH_W-1:0]     wr_ch,
   input  logic [IW-1:0]       wr_addr,
   input  logic [DATA_W-1:0]   wr_data,
   output logic [CHANNELS-1:0] ad_in,
   output logic                busy,
   output logic                exhausted,
   output logic [19:0]         frame_cnt
);

   logic          cs_s1, cs_s2, cs_d;
   logic          clk_s1, clk_s2, clk_d;
   logic          cs_fall;
   logic          shift_en;
   logic [IW-1:0] index;

   // Synchronisers idle high so reset never fabricates an edge.
   always_ff @(posedge clk_50M) begin
      if (!rst_n) begin
         cs_s1  <= 1'b1;
         cs_s2  <= 1'b1;
         cs_d   <= 1'b1;
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         clk_d  <= 1'b1;
      end else begin
         cs_s1  <= ad_cs;
         cs_s2  <= cs_s1;
         cs_d   <= cs_s2;
         clk_s1 <= ad_clk;
         clk_s2 <= clk_s1;
         clk_d  <= clk_s2;
      end
   end

   assign cs_fall  = cs_d & ~cs_s2;
   assign shift_en = clk_d & ~clk_s2 & ~cs_s2;
   assign busy     = ~cs_s2;

   // cycle_start wins over a coincident frame increment.
   always_ff @(posedge clk_50M) begin
      if (!rst_n || cycle_start) begin
         index     <= '0;
         exhausted <= 1'b0;
         frame_cnt <= '0;
      end else if (cs_fall) begin
         if (frame_cnt != '1) frame_cnt <= frame_cnt + 20'd1;
         if (!exhausted) begin
            if (index == IW'(DEPTH - 1)) begin
               if (WRAP != 0) index <= '0;
               else           exhausted <= 1'b1;
            end else begin
               index <= index + IW'(1);
            end
         end
      end
   end

`ifdef ADC_EMU_NOISE_EN
   logic [15:0] lfsr;
   always_ff @(posedge clk_50M) begin
      if (!rst_n)       lfsr <= LFSR_SEED;
      else if (cs_fall) lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
   end
`endif

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic sdo;
      adc_emu_chan_shifter #(
         .CH_ID  (c),
         .DATA_W (DATA_W),
         .LEAD_Z (LEAD_Z),
         .TRAIL_Z(TRAIL_Z),
         .DEPTH  (DEPTH)
      ) u_sh (
         .clk    (clk_50M),
         .rst_n  (rst_n),
         .wr_en  (wr_en && (wr_ch == CH_W'(c))),
         .wr_addr(wr_addr),
         .wr_data(wr_data),
         .index  (index),
         .load   (cs_fall),
         .shift  (shift_en),
         .mode   (mode),
         .zero   (exhausted),
`ifdef ADC_EMU_NOISE_EN
         .noise  (lfsr[1:0]),
`endif
         .sdo    (sdo)
      );
      assign ad_in[c] = sdo & ~cs_s2;
   end

endmodule
